regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 118 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with a zero register, a PC-alias read port, a boolean T register and
// per-register pending-write reservations. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned REG0_IDX = 0,
  parameter int unsigned PC_IDX   = 15,
  parameter int unsigned T_IDX    = 8,
  parameter int unsigned PEEK_IDX = 7
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RegWre,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] Rs,
  input  logic [ADDR_W-1:0] Rt,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] PcAddr0,
  input  logic              ResvValid,
  input  logic [ADDR_W-1:0] ResvReg,
  output logic              ResvReady,
  output logic              Busy1,
  output logic              Busy2,
  output logic [ADDR_W:0]   PendCount,
  output logic [DATA_W-1:0] RegPeek1
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] L_REG0 = ADDR_W'(REG0_IDX);
  localparam logic [ADDR_W-1:0] L_PC   = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] L_T    = ADDR_W'(T_IDX);
  localparam logic [ADDR_W-1:0] L_PEEK = ADDR_W'(PEEK_IDX);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DEPTH-1:0]  w_pend_d;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_d;

  logic              w_wr_ok;
  logic [DATA_W-1:0] w_wr_val;
  logic              w_retire;
  logic              w_resv_spec;
  logic              w_set;
  logic              w_byp1;
  logic              w_byp2;
  logic              w_rs_spec;
  logic              w_rt_spec;

  assign w_wr_ok  = RegWre && (WriteReg != L_REG0) && (WriteReg != L_PC);
  assign w_wr_val = (WriteReg == L_T) ? {{(DATA_W-1){1'b0}}, |WriteData} : WriteData;
  assign w_retire = w_wr_ok && r_pend[WriteReg];

  // Zero and PC reservations are accepted but never tracked.
  assign w_resv_spec = (ResvReg == L_REG0) || (ResvReg == L_PC);
  assign ResvReady   = w_resv_spec || !r_pend[ResvReg] || (w_retire && (WriteReg == ResvReg));
  assign w_set       = ResvValid && ResvReady && !w_resv_spec;

`ifdef REGFILE_BYPASS_EN
  // Gate with Rst so reads stay at their reset values while reset is held.
  assign w_byp1 = Rst && w_wr_ok && (WriteReg == Rs);
  assign w_byp2 = Rst && w_wr_ok && (WriteReg == Rt);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_rs_spec = (Rs == L_REG0) || (Rs == L_PC);
  assign w_rt_spec = (Rt == L_REG0) || (Rt == L_PC);

  always_comb begin
    ReadData1 = r_regs[Rs];
    if (Rs == L_REG0)    ReadData1 = '0;
    else if (Rs == L_PC) ReadData1 = PcAddr0;
    else if (w_byp1)     ReadData1 = w_wr_val;
  end

  always_comb begin
    ReadData2 = r_regs[Rt];
    if (Rt == L_REG0)    ReadData2 = '0;
    else if (Rt == L_PC) ReadData2 = PcAddr0;
    else if (w_byp2)     ReadData2 = w_wr_val;
  end

  assign Busy1 = r_pend[Rs] && !w_rs_spec && !(w_byp1 && w_retire);
  assign Busy2 = r_pend[Rt] && !w_rt_spec && !(w_byp2 && w_retire);

  // Set is applied after clear so a same-index retire+reserve stays pending.
  always_comb begin
    w_pend_d = r_pend;
    if (w_retire) w_pend_d[WriteReg] = 1'b0;
    if (w_set)    w_pend_d[ResvReg]  = 1'b1;
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_set && !w_retire)      w_cnt_d = r_cnt + (ADDR_W+1)'(1);
    else if (!w_set && w_retire) w_cnt_d = r_cnt - (ADDR_W+1)'(1);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_ok) r_regs[WriteReg] <= w_wr_val;
      r_pend <= w_pend_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign PendCount = r_cnt;
  assign RegPeek1  = r_regs[L_PEEK];

endmodule
